bluetooth_encoder: RTL and testbench

- Transmit-side counterpart of the Bluetooth packet decoder.
- Accepts one report at a time (x, y, btn) over a valid/ready handshake and frames it into a fixed byte packet.
- Feeds the packet byte-by-byte to the UART transmitter using a start/done handshake.
- Sits between game logic (cursor/move/status reporting) and the UART TX toward the HC-05 module.

---
 rtl/bt_pkg.sv | 24 ++
 rtl/bt_tx_timer.sv | 36 +++
 rtl/bluetooth_encoder.sv | 180 ++++++++++++++++++
 tb/tb_bluetooth_encoder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_pkg.sv
// rtl/bt_pkg.sv - shared framing constants, FSM states and checksum for the Bluetooth link
package bt_pkg;

    localparam logic [7:0] BT_HEADER    = 8'hA5;
    localparam logic [7:0] BT_TAIL      = 8'h5A;
    localparam int         PKT_LEN_BASE = 5;
    localparam int         PKT_LEN_CHK  = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        GAP,
        FINISH
    } bt_state_e;

    // Same sum the decoder recomputes on receive: 8-bit wraparound.
    function automatic logic [7:0] bt_checksum(input logic [7:0] x,
                                               input logic [7:0] y,
                                               input logic [7:0] btn);
        return x + y + btn;
    endfunction

endpackage

// File: rtl/bt_tx_timer.sv
// rtl/bt_tx_timer.sv - loadable down-counter; expire_o fires on the last enabled cycle
module bt_tx_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A load of N therefore expires after exactly N enabled cycles.
    assign expire_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/bluetooth_encoder.sv
// rtl/bluetooth_encoder.sv - frames (x, y, btn) reports into UART byte packets
// Build option BT_ENC_CHECKSUM_EN inserts an x+y+btn checksum byte before TAIL.
module bluetooth_encoder
    import bt_pkg::*;
#(
    parameter logic [7:0] HEADER     = BT_HEADER,
    parameter logic [7:0] TAIL       = BT_TAIL,
    parameter int         BYTE_GAP   = 16,
    parameter int         TX_TIMEOUT = 200000
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] x_i,
    input  logic [7:0] y_i,
    input  logic [7:0] btn_i,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       busy_o,
    output logic       pkt_done_o,
    output logic       err_o
);

`ifdef BT_ENC_CHECKSUM_EN
    localparam int PKT_LEN = PKT_LEN_CHK;
`else
    localparam int PKT_LEN = PKT_LEN_BASE;
`endif
    localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);
    localparam int GAP_W = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;
    localparam int TO_W  = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;

    bt_state_e  state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       err_q, err_d;
    logic [7:0] x_q, y_q, btn_q;
    logic [7:0] cur_byte;
    logic       accept;
    logic       gap_load, gap_expire;
    logic       to_load, to_en, to_expire;

    assign in_ready   = (state_q == IDLE);
    assign accept     = in_valid && in_ready;
    assign busy_o     = (state_q != IDLE);
    assign pkt_done_o = (state_q == FINISH);
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign err_o      = err_q;

    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            3'd0: cur_byte = HEADER;
            3'd1: cur_byte = x_q;
            3'd2: cur_byte = y_q;
            3'd3: cur_byte = btn_q;
`ifdef BT_ENC_CHECKSUM_EN
            3'd4: cur_byte = bt_checksum(x_q, y_q, btn_q);
            3'd5: cur_byte = TAIL;
`else
            3'd4: cur_byte = TAIL;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        err_d      = 1'b0;
        gap_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                    idx_d   = 3'd0;
                end
            end
            LOAD: begin
                tx_data_d = cur_byte;
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = WAIT;
                end else if (to_expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // tx_done wins over a same-cycle timeout: the byte did go out.
                if (tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        if (BYTE_GAP == 0) begin
                            state_d = LOAD;
                        end else begin
                            state_d  = GAP;
                            gap_load = 1'b1;
                        end
                    end
                end else if (to_expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_expire) begin
                    state_d = LOAD;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Timeout restarts on every byte: on entry to LOAD and again at tx_start.
    assign to_load = ((state_q == LOAD) && !tx_busy) ||
                     ((state_d == LOAD) && (state_q != LOAD));
    assign to_en   = (state_q == LOAD) || (state_q == WAIT);

    bt_tx_timer #(.W(GAP_W)) u_gap_timer (
        .clk_i      (clk),
        .rst_i      (rst_p),
        .load_i     (gap_load),
        .load_val_i (GAP_W'(BYTE_GAP)),
        .en_i       (state_q == GAP),
        .expire_o   (gap_expire)
    );

    bt_tx_timer #(.W(TO_W)) u_timeout_timer (
        .clk_i      (clk),
        .rst_i      (rst_p),
        .load_i     (to_load),
        .load_val_i (TO_W'(TX_TIMEOUT)),
        .en_i       (to_en),
        .expire_o   (to_expire)
    );

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            x_q   <= 8'h00;
            y_q   <= 8'h00;
            btn_q <= 8'h00;
        end else if (accept) begin
            x_q   <= x_i;
            y_q   <= y_i;
            btn_q <= btn_i;
        end
    end

endmodule

// File: tb/tb_bluetooth_encoder.sv
// tb/tb_bluetooth_encoder.sv - scoreboard bench for bluetooth_encoder with a behavioural UART model
module tb_bluetooth_encoder;

    localparam int BYTE_GAP   = 3;
    localparam int TX_TIMEOUT = 100;
    localparam int UART_CYC   = 10;
`ifdef BT_ENC_CHECKSUM_EN
    localparam int PLEN = 6;
`else
    localparam int PLEN = 5;
`endif

    logic       clk = 1'b0;
    logic       rst_p;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x_i, y_i, btn_i;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       busy_o;
    logic       pkt_done_o;
    logic       err_o;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_bytes[$];
    int         exp_evt[$];

    int cyc = 0;
    int acc_cyc = -1;
    int done_cyc = -1;
    int pdone_cyc = -1;
    int start_cyc = -1;
    bit acc_pend = 1'b0;
    bit stalled = 1'b0;
    bit prev_busy = 1'b0;
    int err_ref = 0;
    bit force_busy = 1'b0;
    bit spur_done = 1'b0;
    int suppress_at = -1;
    int nstarts = 0;

    bluetooth_encoder #(
        .BYTE_GAP   (BYTE_GAP),
        .TX_TIMEOUT (TX_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_p      (rst_p),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x_i        (x_i),
        .y_i        (y_i),
        .btn_i      (btn_i),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .busy_o     (busy_o),
        .pkt_done_o (pkt_done_o),
        .err_o      (err_o)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Reference packet: HEADER, x, y, btn, [sum mod 256], TAIL; first nb bytes are expected on the wire.
    task automatic push_pkt(input logic [7:0] x, input logic [7:0] y, input logic [7:0] b,
                            input int nb, input int evt);
        logic [7:0] p[$];
        p.push_back(8'hA5);
        p.push_back(x);
        p.push_back(y);
        p.push_back(b);
`ifdef BT_ENC_CHECKSUM_EN
        p.push_back(8'((int'(x) + int'(y) + int'(b)) % 256));
`endif
        p.push_back(8'h5A);
        for (int i = 0; i < nb && i < p.size(); i++) exp_bytes.push_back(p[i]);
        if (evt != 0) exp_evt.push_back(evt);
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] b,
                        input bit hold, input int nb, input int evt);
        int n = 0;
        while (!in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_send", int'(in_ready), 1);
        x_i      = x;
        y_i      = y;
        btn_i    = b;
        in_valid = 1'b1;
        push_pkt(x, y, b, nb, evt);
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_evt.size() != 0 || exp_bytes.size() != 0 || busy_o) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_done_events", exp_evt.size(), 0);
        check("wait_done_bytes", exp_bytes.size(), 0);
        check("wait_done_busy", int'(busy_o), 0);
    endtask

    // UART model: busy for UART_CYC cycles after tx_start, then a one-cycle tx_done.
    initial begin
        int ucnt;
        bit ubusy;
        bit usup;
        ucnt = 0;
        ubusy = 1'b0;
        usup = 1'b0;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk); #2;
            tx_done = 1'b0;
            if (rst_p) begin
                ucnt  = 0;
                ubusy = 1'b0;
            end else if (tx_start) begin
                ucnt  = UART_CYC;
                ubusy = 1'b1;
                nstarts++;
                usup  = (nstarts == suppress_at);
            end else if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) begin
                    ubusy   = 1'b0;
                    tx_done = !usup;
                end
            end
            if (spur_done) begin
                tx_done   = 1'b1;
                spur_done = 1'b0;
            end
            tx_busy = ubusy | force_busy;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a byte or a packet event.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_p) begin
                if (pkt_done_o || err_o) begin
                    if (exp_evt.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: pkt_done %0d err %0d, none required at cycle %0d",
                                 pkt_done_o, err_o, cyc);
                    end else begin
                        check("event_kind", int'({err_o, pkt_done_o}), exp_evt.pop_front());
                    end
                    if (err_o) begin
                        check("err_busy_cleared", int'(busy_o), 0);
                        check("err_ready_set", int'(in_ready), 1);
                        if (err_ref == 0) check("err_delay_load", cyc - acc_cyc, TX_TIMEOUT + 1);
                        else              check("err_delay_wait", cyc - start_cyc, TX_TIMEOUT);
                    end
                    if (pkt_done_o) pdone_cyc = cyc;
                end
                if (in_valid && in_ready) begin
                    if (pdone_cyc >= 0) check("idle_before_accept", int'(cyc - pdone_cyc >= 1), 1);
                    acc_cyc  = cyc;
                    acc_pend = 1'b1;
                    stalled  = 1'b0;
                end
                if (acc_pend && tx_busy) stalled = 1'b1;
                if (tx_start) begin
                    check("start_while_busy", int'(prev_busy), 0);
                    if (exp_bytes.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: tx_data 0x%02h, no byte required at cycle %0d",
                                 tx_data, cyc);
                    end else begin
                        check("tx_data", int'(tx_data), int'(exp_bytes.pop_front()));
                    end
                    if (acc_pend) begin
                        if (!stalled) check("accept_latency", cyc - acc_cyc, 2);
                        acc_pend = 1'b0;
                    end else if (done_cyc >= 0) begin
                        check("byte_gap", cyc - done_cyc, BYTE_GAP + 2);
                    end
                    start_cyc = cyc;
                end
                if (tx_done) done_cyc = cyc;
                if (busy_o) check("ready_low_when_busy", int'(in_ready), 0);
            end else begin
                acc_pend = 1'b0;
            end
            prev_busy = tx_busy;
        end
    end

    initial begin
        int n;
        rst_p    = 1'b1;
        in_valid = 1'b0;
        x_i      = 8'h00;
        y_i      = 8'h00;
        btn_i    = 8'h00;
        #2;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_pkt_done", int'(pkt_done_o), 0);
        check("rst_err", int'(err_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_p = 1'b0;

        send(8'h12, 8'h34, 8'h01, 1'b0, PLEN, 1);
        wait_done(1000);
        send(8'hFF, 8'h02, 8'h00, 1'b0, PLEN, 1);
        wait_done(1000);

        for (int i = 0; i < 6; i++) begin
            send(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                 8'($urandom_range(255, 0)), 1'b0, PLEN, 1);
            wait_done(1000);
        end

        // Inputs change mid-packet and in_valid stays high: second packet must carry the new x.
        send(8'h12, 8'h34, 8'h01, 1'b1, PLEN, 1);
        x_i = 8'h99;
        n = 0;
        while (!in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_ready_returns", int'(in_ready), 1);
        push_pkt(8'h99, 8'h34, 8'h01, PLEN, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(1000);

        spur_done = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("spurious_done_idle", int'(busy_o), 0);

        force_busy = 1'b1;
        send(8'h21, 8'h43, 8'h65, 1'b0, PLEN, 1);
        repeat (50) @(posedge clk);
        #1;
        force_busy = 1'b0;
        wait_done(1000);

        err_ref = 0;
        force_busy = 1'b1;
        send(8'h0A, 8'h0B, 8'h0C, 1'b0, 0, 2);
        wait_done(500);
        force_busy = 1'b0;
        @(posedge clk); #1;

        err_ref = 1;
        suppress_at = nstarts + 4;
        send(8'h55, 8'h66, 8'h77, 1'b0, 4, 2);
        wait_done(1000);
        suppress_at = -1;
        send(8'h12, 8'h34, 8'h01, 1'b0, PLEN, 1);
        wait_done(1000);

        send(8'h3C, 8'h4D, 8'h5E, 1'b0, PLEN, 1);
        n = 0;
        while (exp_bytes.size() > PLEN - 2 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_byte2", exp_bytes.size(), PLEN - 2);
        repeat (3) @(posedge clk);
        #2;
        rst_p = 1'b1;
        #1;
        check("async_rst_tx_start", int'(tx_start), 0);
        check("async_rst_tx_data", int'(tx_data), 0);
        check("async_rst_busy", int'(busy_o), 0);
        check("async_rst_ready", int'(in_ready), 1);
        exp_bytes.delete();
        exp_evt.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_p = 1'b0;
        send(8'hC3, 8'hD4, 8'hE5, 1'b0, PLEN, 1);
        wait_done(1000);

        repeat (5) @(posedge clk);
        #1;
        check("final_bytes_left", exp_bytes.size(), 0);
        check("final_events_left", exp_evt.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
